// File: rtl/flaf_phi_mac_fold.sv
// Folded FLAF dot product: y = sum_j w[j]*phi[j] over M_TAPS Phi vectors with one multiplier.
// Optional macro FLAF_MAC_PIPE_EN registers the product ahead of the accumulator (+1 cycle latency).
module flaf_phi_mac_fold #(
   parameter int Q_ORD  = 7,
   parameter int M_TAPS = 4,
   parameter int WIDTH  = 16,
   parameter int PHI_QP = 15,
   parameter int W_QP   = 12,
   parameter int ACC_W  = 40
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [Q_ORD*WIDTH-1:0]        phi_in_packed,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [Q_ORD*M_TAPS*WIDTH-1:0] w_packed,
   input  logic                          hist_clr,
   output logic signed [WIDTH-1:0]       y_out,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int N     = Q_ORD * M_TAPS;
   localparam int CNT_W = $clog2(N + 1);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int PRD_W = 2 * WIDTH;
   // The product carries PHI_QP+W_QP fraction bits; y is returned in the weight format.
   localparam int SHIFT = (PHI_QP + W_QP) - W_QP;
`ifdef FLAF_MAC_PIPE_EN
   localparam int LAST  = N;
`else
   localparam int LAST  = N - 1;
`endif
   localparam logic signed [ACC_W-1:0] RND_BIAS = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   function automatic logic signed [ACC_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
      return (a + RND_BIAS) >>> SHIFT;
   endfunction

   function automatic logic signed [WIDTH-1:0] sat_y(input logic signed [ACC_W-1:0] v);
      if (v > Y_MAX)      return Y_MAX[WIDTH-1:0];
      else if (v < Y_MIN) return Y_MIN[WIDTH-1:0];
      else                return v[WIDTH-1:0];
   endfunction

   state_t                    state_q, state_d;
   logic signed [WIDTH-1:0]   hist_q [N];
   logic signed [WIDTH-1:0]   hist_d [N];
   logic signed [WIDTH-1:0]   w_q [N];
   logic signed [WIDTH-1:0]   w_d [N];
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic signed [WIDTH-1:0]   y_q, y_d;
   logic                      vld_q, vld_d;
`ifdef FLAF_MAC_PIPE_EN
   logic signed [ACC_W-1:0]   prod_q, prod_d;
`endif

   logic [IDX_W-1:0]          sel;
   logic signed [WIDTH-1:0]   phi_sel, w_sel;
   logic signed [PRD_W-1:0]   phi_ext, w_ext, prod_full;
   logic signed [ACC_W-1:0]   prod_ext;

   // The pipelined variant runs the counter one step past N; clamp the index there.
   assign sel       = (cnt_q < CNT_W'(N)) ? IDX_W'(cnt_q) : '0;
   assign phi_sel   = hist_q[sel];
   assign w_sel     = w_q[sel];
   assign phi_ext   = {{WIDTH{phi_sel[WIDTH-1]}}, phi_sel};
   assign w_ext     = {{WIDTH{w_sel[WIDTH-1]}}, w_sel};
   assign prod_full = phi_ext * w_ext;
   assign prod_ext  = {{(ACC_W-PRD_W){prod_full[PRD_W-1]}}, prod_full};

   assign in_ready  = (state_q == S_IDLE);
   assign y_out     = y_q;
   assign out_valid = vld_q;

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      w_d     = w_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      vld_d   = vld_q;
`ifdef FLAF_MAC_PIPE_EN
      prod_d  = prod_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // Flat index j = k*Q_ORD+q, so a tap shift is a shift by Q_ORD entries.
               for (int j = Q_ORD; j < N; j++) hist_d[j] = hist_q[j-Q_ORD];
               for (int q = 0; q < Q_ORD; q++) hist_d[q] = phi_in_packed[q*WIDTH +: WIDTH];
               for (int j = 0; j < N; j++)     w_d[j]    = w_packed[j*WIDTH +: WIDTH];
               acc_d   = '0;
               cnt_d   = '0;
`ifdef FLAF_MAC_PIPE_EN
               prod_d  = '0;
`endif
               state_d = S_MAC;
            end else if (hist_clr) begin
               for (int j = 0; j < N; j++) hist_d[j] = '0;
            end
         end
         S_MAC: begin
`ifdef FLAF_MAC_PIPE_EN
            acc_d  = acc_q + prod_q;
            prod_d = prod_ext;
`else
            acc_d  = acc_q + prod_ext;
`endif
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(LAST)) state_d = S_OUT;
         end
         S_OUT: begin
            if (!vld_q) begin
               y_d   = sat_y(round_acc(acc_q));
               vld_d = 1'b1;
            end else if (out_ready) begin
               vld_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         for (int j = 0; j < N; j++) begin
            hist_q[j] <= '0;
            w_q[j]    <= '0;
         end
         acc_q <= '0;
         cnt_q <= '0;
         y_q   <= '0;
         vld_q <= 1'b0;
`ifdef FLAF_MAC_PIPE_EN
         prod_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         w_q     <= w_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         vld_q   <= vld_d;
`ifdef FLAF_MAC_PIPE_EN
         prod_q  <= prod_d;
`endif
      end
   end

endmodule

// File: tb/tb_flaf_phi_mac_fold.sv
// Directed and randomized bench for flaf_phi_mac_fold (Q_ORD=7, M_TAPS=2) with a tap-level reference model.
module tb_flaf_phi_mac_fold;

   localparam int Q_ORD  = 7;
   localparam int M_TAPS = 2;
   localparam int N      = Q_ORD * M_TAPS;
   localparam int W      = 16;
   localparam int PW     = Q_ORD * W;
   localparam int WW     = N * W;
`ifdef FLAF_MAC_PIPE_EN
   localparam int LAT = N + 2;
`else
   localparam int LAT = N + 1;
`endif

   logic          clk;
   logic          reset;
   logic [PW-1:0] phi_in;
   logic          in_valid;
   logic          in_ready;
   logic [WW-1:0] w_in;
   logic          hist_clr;
   logic [W-1:0]  y_out;
   logic          out_valid;
   logic          out_ready;

   int checks = 0;
   int errors = 0;

   // Reference history: mh[k][q] is element q of the sample accepted k samples ago.
   logic signed [W-1:0] mh [M_TAPS][Q_ORD];
   logic [W-1:0]        held_y;

   flaf_phi_mac_fold #(
      .Q_ORD(Q_ORD), .M_TAPS(M_TAPS), .WIDTH(W), .PHI_QP(15), .W_QP(12), .ACC_W(40)
   ) dut (
      .clk(clk), .reset(reset), .phi_in_packed(phi_in), .in_valid(in_valid),
      .in_ready(in_ready), .w_packed(w_in), .hist_clr(hist_clr), .y_out(y_out),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < M_TAPS; k++)
         for (int q = 0; q < Q_ORD; q++) mh[k][q] = '0;
   endtask

   task automatic model_accept(input logic [PW-1:0] phi);
      for (int k = M_TAPS - 1; k > 0; k--)
         for (int q = 0; q < Q_ORD; q++) mh[k][q] = mh[k-1][q];
      for (int q = 0; q < Q_ORD; q++) mh[0][q] = phi[q*W +: W];
   endtask

   // y = round-half-up(sum * 2^-15), clipped to the 16-bit signed range.
   function automatic logic [W-1:0] model_y(input logic [WW-1:0] w);
      longint s = 0;
      for (int k = 0; k < M_TAPS; k++)
         for (int q = 0; q < Q_ORD; q++)
            s += longint'(mh[k][q]) * longint'($signed(w[(k*Q_ORD+q)*W +: W]));
      s = (s + 64'sd16384) >>> 15;
      if (s > 64'sd32767)  s = 64'sd32767;
      if (s < -64'sd32768) s = -64'sd32768;
      return s[W-1:0];
   endfunction

   function automatic logic [PW-1:0] rand_phi();
      logic [PW-1:0] v;
      for (int q = 0; q < Q_ORD; q++) v[q*W +: W] = W'($urandom);
      return v;
   endfunction

   function automatic logic [WW-1:0] rand_w();
      logic [WW-1:0] v;
      for (int j = 0; j < N; j++) v[j*W +: W] = W'(int'($urandom_range(0, 8191)) - 4096);
      return v;
   endfunction

   function automatic logic [PW-1:0] phi_fill(input logic [W-1:0] e);
      logic [PW-1:0] v;
      for (int q = 0; q < Q_ORD; q++) v[q*W +: W] = e;
      return v;
   endfunction

   function automatic logic [WW-1:0] w_fill(input logic [W-1:0] e);
      logic [WW-1:0] v;
      for (int j = 0; j < N; j++) v[j*W +: W] = e;
      return v;
   endfunction

   // Accept one sample, wait (bounded) for out_valid, check latency and value.
   task automatic send(input logic [PW-1:0] phi, input logic [WW-1:0] w, input logic clr,
                       input string tag);
      int          lat;
      logic [W-1:0] exp_y;
      check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
      phi_in   = phi;
      w_in     = w;
      in_valid = 1'b1;
      hist_clr = clr;
      @(posedge clk); #1;
      in_valid = 1'b0;
      hist_clr = 1'b0;
      model_accept(phi);
      exp_y = model_y(w);
      lat   = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(LAT));
      check({tag, "_y"}, 32'(y_out), 32'(exp_y));
      held_y = y_out;
   endtask

   task automatic consume(input string tag);
      @(posedge clk); #1;
      check({tag, "_vld_drop"}, 32'(out_valid), 32'(0));
      check({tag, "_rdy_back"}, 32'(in_ready), 32'(1));
      check({tag, "_y_kept"}, 32'(y_out), 32'(held_y));
   endtask

   initial begin
      logic [WW-1:0] w;
      logic [PW-1:0] phi;

      reset     = 1'b1;
      in_valid  = 1'b0;
      hist_clr  = 1'b0;
      out_ready = 1'b1;
      phi_in    = '0;
      w_in      = '0;
      model_clear();

      // Reset state
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("rst_y", 32'(y_out), 32'h0);
      check("rst_vld", 32'(out_valid), 32'(0));
      check("rst_rdy", 32'(in_ready), 32'(1));

      // Single nonzero product: 0.5 * 1.0
      phi = '0; phi[0 +: W] = 16'h4000;
      w   = '0; w[0 +: W]   = 16'h1000;
      send(phi, w, 1'b0, "basic");
      check("basic_const", 32'(y_out), 32'h0800);
      consume("basic");

      // History: B sees A in tap 1
      send(phi, w, 1'b0, "hist_a");
      consume("hist_a");
      phi = '0; phi[0 +: W] = 16'h2000;
      w   = '0; w[7*W +: W] = 16'h1000;
      send(phi, w, 1'b0, "hist_b");
      check("hist_b_const", 32'(y_out), 32'h0800);
      consume("hist_b");

      // hist_clr in IDLE wipes the taps
      hist_clr = 1'b1;
      @(posedge clk); #1;
      hist_clr = 1'b0;
      model_clear();
      check("clr_rdy", 32'(in_ready), 32'(1));
      send(phi, w, 1'b0, "clr_b");
      check("clr_b_const", 32'(y_out), 32'h0000);
      consume("clr_b");

      // hist_clr together with an accept: the accept wins and tap 1 survives
      send(phi, w, 1'b1, "clr_acc");
      check("clr_acc_const", 32'(y_out), 32'h0400);
      consume("clr_acc");

      // Saturation both ways (two sends to fill both taps)
      send(phi_fill(16'h7FFF), w_fill(16'h7FFF), 1'b0, "sat_fill");
      consume("sat_fill");
      send(phi_fill(16'h7FFF), w_fill(16'h7FFF), 1'b0, "sat_pos");
      check("sat_pos_const", 32'(y_out), 32'h7FFF);
      consume("sat_pos");
      send(phi_fill(16'h7FFF), w_fill(16'h8000), 1'b0, "sat_neg");
      check("sat_neg_const", 32'(y_out), 32'h8000);
      consume("sat_neg");

      // Reset during MAC aborts and loses the history
      phi_in   = rand_phi();
      w_in     = rand_w();
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort_vld", 32'(out_valid), 32'(0));
      check("abort_y", 32'(y_out), 32'h0000);
      model_clear();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_rdy", 32'(in_ready), 32'(1));
      send(phi, w, 1'b0, "abort_b");
      check("abort_b_const", 32'(y_out), 32'h0000);
      consume("abort_b");

      // Back-pressure: result held, new samples refused
      out_ready = 1'b0;
      send(rand_phi(), rand_w(), 1'b0, "bp");
      phi_in   = rand_phi();
      w_in     = rand_w();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_y_hold", 32'(y_out), 32'(held_y));
         check("bp_vld_hold", 32'(out_valid), 32'(1));
         check("bp_rdy_low", 32'(in_ready), 32'(0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_vld_drop", 32'(out_valid), 32'(0));
      check("bp_rdy_back", 32'(in_ready), 32'(1));
      send(rand_phi(), rand_w(), 1'b0, "bp_next");
      consume("bp_next");

      // Randomized samples, occasionally with hist_clr on the accept edge
      for (int i = 0; i < 8; i++) begin
         send(rand_phi(), rand_w(), 1'($urandom_range(0, 1)), "rnd");
         consume("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
